// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and width defaults for the RAM port arbiter (ram_port_arbiter).
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  function automatic logic [1:0] onehot_id(input req_id_t id);
    onehot_id = (id == REQ_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the RAM port arbiter; slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);

  logic              i_f_req;
  logic [ADDR_W-1:0] i_f_addr;
  logic              o_f_gnt;
  logic              o_f_ack;
  logic [DATA_W-1:0] o_f_rdata;

  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_gnt;
  logic              o_d_ack;
  logic [DATA_W-1:0] o_d_rdata;

  logic              o_ram_en;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;

  logic              o_busy;

  modport slave (
    input  i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_ram_rdata,
    output o_f_gnt, o_f_ack, o_f_rdata, o_d_gnt, o_d_ack, o_d_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_busy
  );

  modport master (
    output i_f_req, i_f_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_ram_rdata,
    input  o_f_gnt, o_f_ack, o_f_rdata, o_d_gnt, o_d_ack, o_d_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_busy
  );

endinterface

// File: rtl/ram_port_arbiter_pick.sv
// Combinational two-way grant picker. RR_ARB_EN selects round-robin,
// otherwise D has fixed priority over F.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_f,
  input  logic       req_d,
`ifdef RR_ARB_EN
  input  req_id_t    last_id,
`endif
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant, only when enabled and the matching request is high
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_f && req_d) begin
`ifdef RR_ARB_EN
        gnt = (last_id == REQ_D) ? onehot_id(REQ_F) : onehot_id(REQ_D);
`else
        gnt = onehot_id(REQ_D);
`endif
      end else if (req_d) begin
        gnt = onehot_id(REQ_D);
      end else if (req_f) begin
        gnt = onehot_id(REQ_F);
      end else begin
        gnt = 2'b00;
      end
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between fetch (F) and data (D) requesters.
// Define RR_ARB_EN for round-robin arbitration; default is fixed D-over-F priority.
module ram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RAM_LAT = 1
) (
  input logic               i_clk,
  input logic               i_reset,
  ram_port_arbiter_if.slave bus
);

  localparam int LAT_W = $clog2(RAM_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_LAT - 1);

  arb_state_t        state_r;
  req_id_t           id_r;
  logic              we_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic              ram_en_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              f_ack_r;
  logic              d_ack_r;
  logic [DATA_W-1:0] f_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              busy_r;
`ifdef RR_ARB_EN
  req_id_t           last_r;
`endif

  logic [1:0]        gnt_s;
  logic              pick_en_s;
  req_id_t           win_s;

  // No grant is offered while reset is being applied
  assign pick_en_s = (state_r == IDLE) && !i_reset;
  assign win_s     = gnt_s[REQ_D] ? REQ_D : REQ_F;

  arb_pick u_pick (
    .req_f   (bus.i_f_req),
    .req_d   (bus.i_d_req),
`ifdef RR_ARB_EN
    .last_id (last_r),
`endif
    .en      (pick_en_s),
    .gnt     (gnt_s)
  );

  assign bus.o_f_gnt     = gnt_s[REQ_F];
  assign bus.o_d_gnt     = gnt_s[REQ_D];
  assign bus.o_f_ack     = f_ack_r;
  assign bus.o_d_ack     = d_ack_r;
  assign bus.o_f_rdata   = f_rdata_r;
  assign bus.o_d_rdata   = d_rdata_r;
  assign bus.o_ram_en    = ram_en_r;
  assign bus.o_ram_we    = ram_we_r;
  assign bus.o_ram_addr  = ram_addr_r;
  assign bus.o_ram_wdata = ram_wdata_r;
  assign bus.o_busy      = busy_r;

  // Access sequencer: outputs are set on the edge entering the state they belong to
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      id_r        <= REQ_D;
      we_r        <= 1'b0;
      lat_cnt_r   <= {LAT_W{1'b0}};
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      f_ack_r     <= 1'b0;
      d_ack_r     <= 1'b0;
      f_rdata_r   <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
`ifdef RR_ARB_EN
      last_r      <= REQ_D;
`endif
    end else begin
      ram_en_r <= 1'b0;
      ram_we_r <= 1'b0;
      f_ack_r  <= 1'b0;
      d_ack_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|gnt_s) begin
            state_r  <= ACCESS;
            busy_r   <= 1'b1;
            ram_en_r <= 1'b1;
            id_r     <= win_s;
`ifdef RR_ARB_EN
            last_r   <= win_s;
`endif
            if (win_s == REQ_D) begin
              we_r        <= bus.i_d_we;
              ram_we_r    <= bus.i_d_we;
              ram_addr_r  <= bus.i_d_addr;
              ram_wdata_r <= bus.i_d_wdata;
            end else begin
              we_r        <= 1'b0;
              ram_we_r    <= 1'b0;
              ram_addr_r  <= bus.i_f_addr;
              ram_wdata_r <= {DATA_W{1'b0}};
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ACCESS: begin
          state_r   <= WAIT;
          lat_cnt_r <= LAT_LOAD;
        end
        WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_r <= RESP;
            f_ack_r <= (id_r == REQ_F);
            d_ack_r <= (id_r == REQ_D);
            // Read data is valid on the last WAIT cycle; writes leave rdata alone
            if (!we_r) begin
              if (id_r == REQ_D) begin
                d_rdata_r <= bus.i_ram_rdata;
              end else begin
                f_rdata_r <= bus.i_ram_rdata;
              end
            end
          end else begin
            lat_cnt_r <= lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (RAM_LAT=1 and RAM_LAT=3 instances).
module tb_ram_port_arbiter;
  import mem_arb_pkg::*;

`ifdef RR_ARB_EN
  localparam logic       FIRST_D  = 1'b0;
  localparam logic [3:0] HOLD_SEQ = 4'b1010;
`else
  localparam logic       FIRST_D  = 1'b1;
  localparam logic [3:0] HOLD_SEQ = 4'b1111;
`endif

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 i_clk = ~i_clk;

  ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus  ();
  ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus3 ();

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus)
  );

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RAM_LAT(3)) dut3 (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus3)
  );

  logic [31:0] mem [0:255];
  logic [31:0] s0, s1, s2;

  // Single-cycle synchronous RAM for dut, preloaded while reset is high
  always @(posedge i_clk) begin
    if (i_reset) begin
      mem[8'h04] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hCAFEF00D;
    end else if (bus.o_ram_en) begin
      if (bus.o_ram_we) mem[bus.o_ram_addr[7:0]] <= bus.o_ram_wdata;
      bus.i_ram_rdata <= mem[bus.o_ram_addr[7:0]];
    end
  end

  // Three-cycle read pipeline for dut3
  always @(posedge i_clk) begin
    s0 <= bus3.o_ram_en ? mem[bus3.o_ram_addr[7:0]] : 32'h0;
    s1 <= s0;
    s2 <= s1;
  end
  assign bus3.i_ram_rdata = s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called in the grant cycle T with requests already driven; returns in T+4
  task automatic txn(input string tag, input logic exp_d, input logic [15:0] exp_addr,
                     input logic [31:0] exp_data, input logic drop_f, input logic drop_d);
    chk({tag, ".gnt_f"}, {31'd0, bus.o_f_gnt}, {31'd0, !exp_d});
    chk({tag, ".gnt_d"}, {31'd0, bus.o_d_gnt}, {31'd0, exp_d});
    tick();
    if (drop_f) bus.i_f_req = 1'b0;
    if (drop_d) bus.i_d_req = 1'b0;
    #1;
    chk({tag, ".acc_en"}, {31'd0, bus.o_ram_en}, 32'd1);
    chk({tag, ".acc_we"}, {31'd0, bus.o_ram_we}, 32'd0);
    chk({tag, ".acc_addr"}, {16'd0, bus.o_ram_addr}, {16'd0, exp_addr});
    chk({tag, ".busy_gnt"}, {30'd0, bus.o_f_gnt, bus.o_d_gnt}, 32'd0);
    tick();
    chk({tag, ".wait_en"}, {31'd0, bus.o_ram_en}, 32'd0);
    chk({tag, ".wait_busy"}, {31'd0, bus.o_busy}, 32'd1);
    tick();
    chk({tag, ".ack_f"}, {31'd0, bus.o_f_ack}, {31'd0, !exp_d});
    chk({tag, ".ack_d"}, {31'd0, bus.o_d_ack}, {31'd0, exp_d});
    chk({tag, ".rdata"}, exp_d ? bus.o_d_rdata : bus.o_f_rdata, exp_data);
    tick();
    chk({tag, ".idle_busy"}, {31'd0, bus.o_busy}, 32'd0);
    chk({tag, ".idle_ack"}, {30'd0, bus.o_f_ack, bus.o_d_ack}, 32'd0);
  endtask

  initial begin
    bus.i_f_req  = 1'b0; bus.i_f_addr  = 16'h0000;
    bus.i_d_req  = 1'b0; bus.i_d_we    = 1'b0;
    bus.i_d_addr = 16'h0000; bus.i_d_wdata = 32'h0;
    bus3.i_f_req = 1'b0; bus3.i_f_addr = 16'h0000;
    bus3.i_d_req = 1'b0; bus3.i_d_we   = 1'b0;
    bus3.i_d_addr = 16'h0000; bus3.i_d_wdata = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst.busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst.ram", {30'd0, bus.o_ram_en, bus.o_ram_we}, 32'd0);
    chk("rst.ack", {30'd0, bus.o_f_ack, bus.o_d_ack}, 32'd0);
    chk("rst.f_rdata", bus.o_f_rdata, 32'd0);
    chk("rst.d_rdata", bus.o_d_rdata, 32'd0);
    chk("rst.addr", {16'd0, bus.o_ram_addr}, 32'd0);
    i_reset = 1'b0;

    // Both requesters held for four transactions from a fresh reset
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0020;
    bus.i_d_req = 1'b1; bus.i_d_addr = 16'h0004; bus.i_d_we = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      txn("hold", HOLD_SEQ[i], HOLD_SEQ[i] ? 16'h0004 : 16'h0020,
          HOLD_SEQ[i] ? 32'hDEADBEEF : 32'hCAFEF00D, i == 3, i == 3);
    end

    // F read only
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0004;
    #1;
    txn("f_rd", 1'b0, 16'h0004, 32'hDEADBEEF, 1'b1, 1'b0);

    // D write
    bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_addr = 16'h0010; bus.i_d_wdata = 32'h12345678;
    #1;
    chk("d_wr.gnt", {30'd0, bus.o_f_gnt, bus.o_d_gnt}, 32'd1);
    tick();
    bus.i_d_req = 1'b0; bus.i_d_we = 1'b0;
    #1;
    chk("d_wr.en", {30'd0, bus.o_ram_en, bus.o_ram_we}, 32'd3);
    chk("d_wr.addr", {16'd0, bus.o_ram_addr}, 32'h0000_0010);
    chk("d_wr.wdata", bus.o_ram_wdata, 32'h12345678);
    tick();
    chk("d_wr.wait_we", {31'd0, bus.o_ram_we}, 32'd0);
    tick();
    chk("d_wr.ack", {30'd0, bus.o_f_ack, bus.o_d_ack}, 32'd1);
    chk("d_wr.rdata_kept", bus.o_d_rdata, 32'hDEADBEEF);
    tick();
    chk("d_wr.idle", {31'd0, bus.o_busy}, 32'd0);

    // D read back
    bus.i_d_req = 1'b1; bus.i_d_addr = 16'h0010;
    #1;
    txn("d_rd", 1'b1, 16'h0010, 32'h12345678, 1'b0, 1'b1);
    chk("d_rd.f_rdata_hold", bus.o_f_rdata, 32'hDEADBEEF);

    // Reset while in WAIT
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0004;
    #1;
    chk("rstw.gnt", {31'd0, bus.o_f_gnt}, 32'd1);
    tick();
    bus.i_f_req = 1'b0;
    #1;
    chk("rstw.acc", {31'd0, bus.o_ram_en}, 32'd1);
    tick();
    i_reset = 1'b1;
    #1;
    chk("rstw.wait_busy", {31'd0, bus.o_busy}, 32'd1);
    tick();
    i_reset = 1'b0;
    #1;
    chk("rstw.busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rstw.ram", {30'd0, bus.o_ram_en, bus.o_ram_we}, 32'd0);
    chk("rstw.ack", {30'd0, bus.o_f_ack, bus.o_d_ack}, 32'd0);
    chk("rstw.f_rdata", bus.o_f_rdata, 32'd0);
    tick();
    chk("rstw.no_late_ack", {30'd0, bus.o_f_ack, bus.o_d_ack}, 32'd0);

    // Simultaneous requests, each dropped once granted
    bus.i_f_req = 1'b1; bus.i_f_addr = 16'h0020;
    bus.i_d_req = 1'b1; bus.i_d_addr = 16'h0004; bus.i_d_we = 1'b0;
    #1;
    txn("sim1", FIRST_D, FIRST_D ? 16'h0004 : 16'h0020,
        FIRST_D ? 32'hDEADBEEF : 32'hCAFEF00D, !FIRST_D, FIRST_D);
    txn("sim2", !FIRST_D, FIRST_D ? 16'h0020 : 16'h0004,
        FIRST_D ? 32'hCAFEF00D : 32'hDEADBEEF, FIRST_D, !FIRST_D);

    // RAM_LAT=3 instance: ack at T+5, busy T+1..T+5
    bus3.i_f_req = 1'b1; bus3.i_f_addr = 16'h0004;
    #1;
    chk("lat3.gnt", {31'd0, bus3.o_f_gnt}, 32'd1);
    tick();
    bus3.i_f_req = 1'b0;
    #1;
    chk("lat3.acc", {30'd0, bus3.o_ram_en, bus3.o_busy}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lat3.wait", {30'd0, bus3.o_busy, bus3.o_f_ack}, 32'd2);
    end
    tick();
    chk("lat3.ack", {30'd0, bus3.o_busy, bus3.o_f_ack}, 32'd3);
    chk("lat3.rdata", bus3.o_f_rdata, 32'hDEADBEEF);
    tick();
    chk("lat3.idle", {30'd0, bus3.o_busy, bus3.o_f_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the processor's single-port synchronous RAM between two requesters: the instruction-fetch unit (F) and the load/store execute unit (D).
- Arbitrates requests, drives the RAM address, write-data, enable and write-enable lines, and waits out the RAM read latency.
- Returns the read data and a one-cycle acknowledge to whichever requester won.
- Sits between the processor state machine and the RAM instance; only one access is in flight at a time.

Parameters:
- ADDR_W, 16, RAM word-address width
- DATA_W, 32, RAM data width
- RAM_LAT, 1, cycles from the ACCESS cycle until i_ram_rdata is valid (>=1)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_f_req  in  1  fetch request; held until o_f_gnt
- i_f_addr  in  ADDR_W  fetch address
- o_f_gnt  out  1  fetch request accepted this cycle
- o_f_ack  out  1  one-cycle pulse: fetch data valid
- o_f_rdata  out  DATA_W  fetched word
- i_d_req  in  1  data request; held until o_d_gnt
- i_d_we  in  1  1 = write, 0 = read
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  write data
- o_d_gnt  out  1  data request accepted this cycle
- o_d_ack  out  1  one-cycle pulse: read data valid or write done
- o_d_rdata  out  DATA_W  loaded word
- o_ram_en  out  1  RAM access strobe
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: one clock, synchronous, active-high (i_clk, i_reset). The block is in IDLE, all outputs are 0, and the last-grant pointer is set to D.
- States:
  - IDLE -> ACCESS on any grant.
  - ACCESS -> WAIT after 1 cycle.
  - WAIT -> RESP after RAM_LAT cycles, counted by a latency counter.
  - RESP -> IDLE after 1 cycle.
- Grant is combinational and occurs only in IDLE. At most one of o_f_gnt/o_d_gnt is high. A grant requires the matching req to be high.
- Priority on simultaneous requests: D wins (fixed priority) unless RR_ARB_EN is defined.
- On grant, the winner's id, addr, we and wdata are registered. For F, we is always 0.
- ACCESS: o_ram_en=1, o_ram_addr/o_ram_we/o_ram_wdata come from the registered values. In all other states o_ram_en=0 and o_ram_we=0.
- WAIT: on its last cycle, a read captures i_ram_rdata into the winner's rdata register.
- RESP: the winner's ack is 1 for exactly one cycle. For a read, that requester's rdata is valid in the same cycle. A write acks with rdata unchanged.
- Latency (RAM_LAT=1):
  - grant at cycle T, ACCESS at T+1, WAIT at T+2, ack at T+3;
  - next grant possible at T+4;
  - general form: ack at T+2+RAM_LAT.
- o_f_rdata/o_d_rdata hold their value until that requester's next read ack.
- A requester that deasserts req before gnt is simply not served; there is no error.
- A request arriving while the block is busy waits; no request is lost while it is held.
- Reset mid-operation:
  - the transaction is aborted; no ack is produced;
  - o_ram_en/o_ram_we are 0 from the cycle after the reset edge;
  - the pointer returns to D.
- Addresses are passed through unmodified; there is no wrap or bounds logic.

Optional Feature:
- Macro: RR_ARB_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, the requester that was not granted last wins.
  - The last-grant pointer updates on every grant.
  - A single requester is always granted regardless of the pointer.
- Undefined: fixed priority, D over F. The pointer register is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - the ADDR_W and DATA_W defaults;
  - enum req_id_t {REQ_F, REQ_D};
  - enum arb_state_t {IDLE, ACCESS, WAIT, RESP}.
- Sub-module arb_pick is purely combinational:
  - inputs: two reqs, last-grant id, enable;
  - outputs: one-hot grant;
  - round-robin vs fixed priority is selected by RR_ARB_EN.

Test Plan:
- F read only: F req at addr 0x0004 with RAM[4]=0xDEADBEEF -> o_f_gnt at T, o_ram_en=1 with addr 0x0004 at T+1, o_f_ack=1 with o_f_rdata=0xDEADBEEF at T+3, o_busy low at T+4.
- D write then D read: write 0x12345678 to 0x0010 -> o_ram_we=1 in ACCESS, o_d_ack at T+3. Read of 0x0010 -> o_d_rdata=0x12345678.
- Simultaneous F and D, fixed priority: D granted first. F stays pending and is granted in the first IDLE after D's RESP. Each ack goes only to its own requester.
- Simultaneous F and D held over 4 transactions, RR_ARB_EN defined -> grant order F, D, F, D (pointer starts at D).
- Reset in WAIT: assert i_reset for 1 cycle -> no ack, o_ram_en=0, o_busy=0 afterwards. A new F request is then served normally.
- RAM_LAT=3 build: F read -> ack at T+5 and o_busy high for cycles T+1..T+5.
